// File: rtl/cache_row_packer.sv
// Packs a 64-bit row stream into 512-bit cache lines on a data BRAM port and
// records one {start line, beat count} metadata entry per row on a metadata BRAM port.
module cache_row_packer #(
  parameter int C_BRAM_DATA_WIDTH     = 512,
  parameter int C_BRAM_METADATA_WIDTH = 32,
  parameter int C_BRAM_ADDR_WIDTH     = 32,
  parameter int C_STREAM_WIDTH        = 64,
  parameter int DATA_RAM_DEPTH        = 32768,
  parameter int METADATA_RAM_DEPTH    = 32768
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [31:0]                        cfg_base_line,
  input  logic [15:0]                        cfg_num_rows,
  output logic                               busy,
  output logic                               done,
  input  logic                               s_valid,
  output logic                               s_ready,
  input  logic [C_STREAM_WIDTH-1:0]          s_data,
  input  logic                               s_last,
  output logic                               data_en,
  output logic [C_BRAM_DATA_WIDTH/8-1:0]     data_we,
  output logic [C_BRAM_ADDR_WIDTH-1:0]       data_addr,
  output logic [C_BRAM_DATA_WIDTH-1:0]       data_din,
  output logic                               meta_en,
  output logic [C_BRAM_METADATA_WIDTH/8-1:0] meta_we,
  output logic [C_BRAM_ADDR_WIDTH-1:0]       meta_addr,
  output logic [C_BRAM_METADATA_WIDTH-1:0]   meta_din
);

  localparam int BEATS = C_BRAM_DATA_WIDTH / C_STREAM_WIDTH;
  localparam int BW    = $clog2(BEATS);
  localparam int LW    = $clog2(DATA_RAM_DEPTH);
  localparam int MW    = $clog2(METADATA_RAM_DEPTH);
  localparam int BB    = C_STREAM_WIDTH / 8;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_t;

  state_t                         r_state;
  state_t                         w_state_nxt;
  logic [15:0]                    r_num_rows;
  logic [LW-1:0]                  r_line_ptr;
  logic [LW-1:0]                  r_row_start;
  logic [15:0]                    r_row_idx;
  logic [BW-1:0]                  r_beat_cnt;
  logic [15:0]                    r_row_beats;
  logic [C_BRAM_DATA_WIDTH-1:0]   r_line;
  logic [C_BRAM_DATA_WIDTH/8-1:0] r_mask;

  logic                           w_start_run;
  logic                           w_accept;
  logic                           w_line_wr;
  logic                           w_row_end;
  logic                           w_final_row;
  logic [15:0]                    w_beats_inc;
  logic [C_BRAM_DATA_WIDTH-1:0]   w_line;
  logic [C_BRAM_DATA_WIDTH/8-1:0] w_mask;

  assign w_start_run = (r_state == S_IDLE) && start && (cfg_num_rows != 16'd0);
  assign w_accept    = (r_state == S_RUN) && s_valid;
  assign w_line_wr   = w_accept && (s_last || (r_beat_cnt == BW'(BEATS - 1)));
  assign w_row_end   = w_accept && s_last;
  assign w_final_row = w_row_end && (r_row_idx == (r_num_rows - 16'd1));
  assign w_beats_inc = (r_row_beats == 16'hFFFF) ? 16'hFFFF : (r_row_beats + 16'd1);

  // Line buffer with the incoming beat merged into its lane
  always_comb begin
    w_line = r_line;
    w_mask = r_mask;
    if (w_accept) begin
      w_line[int'(r_beat_cnt)*C_STREAM_WIDTH +: C_STREAM_WIDTH] = s_data;
      w_mask[int'(r_beat_cnt)*BB +: BB] = {BB{1'b1}};
    end else begin
      w_line = r_line;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = w_start_run ? S_RUN : S_IDLE;
      S_RUN:   w_state_nxt = w_final_row ? S_DRAIN : S_RUN;
      S_DRAIN: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Datapath, counters and registered BRAM/handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_num_rows <= 16'd0;   r_line_ptr <= '0;      r_row_start <= '0;
      r_row_idx  <= 16'd0;   r_beat_cnt <= '0;      r_row_beats <= 16'd0;
      r_line     <= '0;      r_mask     <= '0;
      busy       <= 1'b0;    done       <= 1'b0;    s_ready     <= 1'b0;
      data_en    <= 1'b0;    data_we    <= '0;      data_addr   <= '0;     data_din <= '0;
      meta_en    <= 1'b0;    meta_we    <= '0;      meta_addr   <= '0;     meta_din <= '0;
    end else begin
      busy    <= (w_state_nxt != S_IDLE);
      s_ready <= (w_state_nxt == S_RUN);
      done    <= (r_state == S_DRAIN) ||
                 ((r_state == S_IDLE) && start && (cfg_num_rows == 16'd0));
      data_en <= w_line_wr;
      data_we   <= w_line_wr ? w_mask : '0;
      data_addr <= w_line_wr ? C_BRAM_ADDR_WIDTH'(r_line_ptr) : '0;
      data_din  <= w_line_wr ? w_line : '0;
      meta_en   <= w_row_end;
      meta_we   <= w_row_end ? {(C_BRAM_METADATA_WIDTH/8){1'b1}} : '0;
      meta_addr <= w_row_end ? C_BRAM_ADDR_WIDTH'(r_row_idx[MW-1:0]) : '0;
      meta_din  <= w_row_end ? C_BRAM_METADATA_WIDTH'({16'(r_row_start), w_beats_inc}) : '0;
      if (w_start_run) begin
        r_num_rows  <= cfg_num_rows;
        r_line_ptr  <= LW'(cfg_base_line % 32'(DATA_RAM_DEPTH));
        r_row_start <= LW'(cfg_base_line % 32'(DATA_RAM_DEPTH));
        r_row_idx   <= 16'd0;
        r_beat_cnt  <= '0;
        r_row_beats <= 16'd0;
        r_line      <= '0;
        r_mask      <= '0;
      end else if (w_accept) begin
        if (w_line_wr) begin
          r_line     <= '0;
          r_mask     <= '0;
          r_beat_cnt <= '0;
          r_line_ptr <= r_line_ptr + LW'(1);
        end else begin
          r_line     <= w_line;
          r_mask     <= w_mask;
          r_beat_cnt <= r_beat_cnt + BW'(1);
        end
        // A row end always coincides with a line write, so the next row opens on the next line
        if (w_row_end) begin
          r_row_start <= r_line_ptr + LW'(1);
          r_row_idx   <= r_row_idx + 16'd1;
          r_row_beats <= 16'd0;
        end else begin
          r_row_beats <= w_beats_inc;
        end
      end else begin
        r_beat_cnt <= r_beat_cnt;
      end
    end
  end

endmodule

// File: tb/tb_cache_row_packer.sv
// Scoreboard bench for cache_row_packer: a line/row model fills expectation queues,
// a negedge monitor pops and compares every BRAM write.
module tb_cache_row_packer;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [31:0]  cfg_base_line;
  logic [15:0]  cfg_num_rows;
  logic         busy, done, s_valid, s_ready, s_last;
  logic [63:0]  s_data;
  logic         data_en, meta_en;
  logic [63:0]  data_we;
  logic [31:0]  data_addr, meta_addr, meta_din;
  logic [511:0] data_din;
  logic [3:0]   meta_we;

  cache_row_packer dut (
    .clk(clk), .rst(rst), .start(start), .cfg_base_line(cfg_base_line),
    .cfg_num_rows(cfg_num_rows), .busy(busy), .done(done), .s_valid(s_valid),
    .s_ready(s_ready), .s_data(s_data), .s_last(s_last), .data_en(data_en),
    .data_we(data_we), .data_addr(data_addr), .data_din(data_din), .meta_en(meta_en),
    .meta_we(meta_we), .meta_addr(meta_addr), .meta_din(meta_din)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [63:0] we; logic [511:0] din; } dexp_t;
  typedef struct { logic [31:0] addr; logic [31:0] din; } mexp_t;

  dexp_t dq[$];
  mexp_t mq[$];
  int    rows_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic any_out();
    return busy | done | s_ready | data_en | (|data_we) | (|data_addr) | (|data_din) |
           meta_en | (|meta_we) | (|meta_addr) | (|meta_din);
  endfunction

  // Monitor: every write must match the head of its queue; idle ports must be all zero
  always @(negedge clk) begin
    if (!rst) begin
      if (data_en) begin
        if (dq.size() == 0) check("data_unexpected", 1'b1, 1'b0);
        else begin
          dexp_t e;
          e = dq.pop_front();
          check("data_addr", data_addr, e.addr);
          check("data_we", data_we, e.we);
          check("data_din", data_din, e.din);
        end
      end else if ((|data_we) || (|data_addr) || (|data_din)) begin
        check("data_idle_zero", 1'b1, 1'b0);
      end
      if (meta_en) begin
        if (mq.size() == 0) check("meta_unexpected", 1'b1, 1'b0);
        else begin
          mexp_t m;
          m = mq.pop_front();
          check("meta_we", meta_we, 4'hF);
          check("meta_addr", meta_addr, m.addr);
          check("meta_din", meta_din, m.din);
        end
      end else if ((|meta_we) || (|meta_addr) || (|meta_din)) begin
        check("meta_idle_zero", 1'b1, 1'b0);
      end
    end
  end

  // Reference: rows chop into 8-beat lines laid out consecutively from base, wrapping at 32768
  task automatic model(input logic [31:0] base, input logic [63:0] beats[$]);
    int line_ctr = 0;
    int b = 0;
    for (int r = 0; r < rows_q.size(); r++) begin
      int rem = rows_q[r];
      int start_line = (int'(base % 32'd32768) + line_ctr) % 32768;
      while (rem > 0) begin
        dexp_t e;
        int k = (rem > 8) ? 8 : rem;
        e.addr = 32'((int'(base % 32'd32768) + line_ctr) % 32768);
        e.we = 64'd0;
        e.din = 512'd0;
        for (int j = 0; j < k; j++) begin
          e.we[8*j +: 8] = 8'hFF;
          e.din[64*j +: 64] = beats[b + j];
        end
        dq.push_back(e);
        b += k;
        rem -= k;
        line_ctr++;
      end
      begin
        mexp_t m;
        m.addr = 32'(r % 32768);
        m.din = {16'(start_line), 16'(rows_q[r])};
        mq.push_back(m);
      end
    end
  endtask

  // One complete fill; ign_at >= 0 pulses a stray start (with junk cfg) on that beat
  task automatic run_fill(input logic [31:0] base, input bit gaps, input bit idx_data, input int ign_at);
    logic [63:0] beats[$];
    int b = 0;
    foreach (rows_q[r]) for (int i = 0; i < rows_q[r]; i++)
      beats.push_back(idx_data ? 64'(b + i + 1) : {$urandom, $urandom});
    model(base, beats);
    @(posedge clk); #1;
    start = 1'b1; cfg_base_line = base; cfg_num_rows = 16'(rows_q.size());
    @(posedge clk); #1;
    start = 1'b0; cfg_base_line = $urandom; cfg_num_rows = 16'($urandom);
    @(negedge clk);
    check("run_busy", busy, 1'b1);
    check("run_ready", s_ready, 1'b1);
    @(posedge clk); #1;
    foreach (rows_q[r]) begin
      for (int i = 0; i < rows_q[r]; i++) begin
        while (gaps && ($urandom_range(0, 2) == 0)) begin
          s_valid = 1'b0; s_data = {$urandom, $urandom}; s_last = $urandom_range(0, 1) == 1;
          @(negedge clk);
          if (s_ready !== 1'b1) check("ready_gap", s_ready, 1'b1);
          @(posedge clk); #1;
        end
        s_valid = 1'b1; s_data = beats[b]; s_last = (i == rows_q[r] - 1);
        if (b == ign_at) begin
          start = 1'b1; cfg_base_line = $urandom; cfg_num_rows = 16'($urandom_range(1, 9));
        end
        @(negedge clk);
        if (s_ready !== 1'b1) check("ready_beat", s_ready, 1'b1);
        @(posedge clk); #1;
        start = 1'b0;
        b++;
      end
    end
    s_valid = 1'b0; s_last = 1'b0;
    @(negedge clk);
    check("drain_busy", busy, 1'b1);
    check("drain_done", done, 1'b0);
    check("drain_ready", s_ready, 1'b0);
    @(negedge clk);
    check("done_pulse", done, 1'b1);
    check("done_busy", busy, 1'b0);
    @(negedge clk);
    check("done_clear", done, 1'b0);
    check("data_q_empty", 32'(dq.size()), 32'd0);
    check("meta_q_empty", 32'(mq.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; cfg_base_line = 32'd0; cfg_num_rows = 16'd0;
    s_valid = 1'b0; s_data = 64'd0; s_last = 1'b0;
    #1;
    check("reset_outputs", any_out(), 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    rows_q = '{8};        run_fill(32'd0, 1'b0, 1'b1, -1);      // T1
    rows_q = '{11, 5};    run_fill(32'd0, 1'b0, 1'b0, -1);      // T2
    rows_q = '{16};       run_fill(32'd32767, 1'b0, 1'b0, -1);  // T3
    rows_q = '{8};        run_fill(32'd0, 1'b1, 1'b1, -1);      // T4
    rows_q = '{3, 9, 4};  run_fill(32'd100, 1'b0, 1'b0, 5);     // stray start mid-run

    // T5: reset three beats into a row
    @(posedge clk); #1;
    start = 1'b1; cfg_base_line = 32'd7; cfg_num_rows = 16'd1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = {$urandom, $urandom}; s_last = 1'b0;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    check("midrow_reset_outputs", any_out(), 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; s_valid = 1'b0;
    rows_q = '{8};        run_fill(32'd0, 1'b0, 1'b1, -1);

    // T6: zero rows, plus stream activity while idle
    s_valid = 1'b1; s_last = 1'b1; s_data = 64'hDEAD_BEEF_0000_0001;
    @(posedge clk); #1;
    start = 1'b1; cfg_base_line = 32'd5; cfg_num_rows = 16'd0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("zero_rows_done", done, 1'b1);
    check("zero_rows_busy", busy, 1'b0);
    check("idle_ready", s_ready, 1'b0);
    @(negedge clk);
    check("zero_rows_done_clear", done, 1'b0);
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;

    // Randomized fills
    for (int t = 0; t < 12; t++) begin
      int nr = $urandom_range(1, 4);
      rows_q.delete();
      for (int r = 0; r < nr; r++) rows_q.push_back($urandom_range(1, 20));
      run_fill((t % 3 == 0) ? (32'd32760 + 32'($urandom_range(0, 7))) : $urandom,
               $urandom_range(0, 1) == 1, 1'b0, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
